// File: rtl/imm_field_packer.sv
// rtl/imm_field_packer.sv - range-checked immediate packer with valid/ready output stage and write-address counter
// Optional macro: IMM_PACKER_STRICT_RANGE_EN (defined: out-of-range immediates are rejected;
// undefined: sign taken from Imm[63], field truncated, only Fmt=11 rejects).
module imm_field_packer #(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ERR_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 Clear,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic [1:0]           Fmt,
    input  logic [63:0]          Imm,
    input  logic [4:0]           Rn,
    input  logic [4:0]           Rt,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [31:0]          InstOut,
    output logic [ADDR_W-1:0]    WrAddr,
    output logic                 ErrFlag,
    output logic [ERR_CNT_W-1:0] ErrCount
);

    localparam logic [1:0] FMT_B  = 2'b00;
    localparam logic [1:0] FMT_D  = 2'b01;
    localparam logic [1:0] FMT_CB = 2'b10;

    logic                 out_valid_q, out_valid_d;
    logic [31:0]          inst_q, inst_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 err_flag_q, err_flag_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Per-format "fits the field" and "use the one-extending opcode" decisions.
    logic ok_b, ok_d, ok_cb;
    logic neg_b, neg_d, neg_cb;

`ifdef IMM_PACKER_STRICT_RANGE_EN
    logic hi26_zero, hi26_ones, hi8_zero, hi8_ones, hi19_zero, hi19_ones;
    assign hi26_zero = ~|Imm[63:26];
    assign hi26_ones = &Imm[63:26];
    assign hi8_zero  = ~|Imm[63:8];
    assign hi8_ones  = &Imm[63:8];
    assign hi19_zero = ~|Imm[63:19];
    assign hi19_ones = &Imm[63:19];
    assign ok_b   = hi26_zero | hi26_ones;
    assign ok_d   = hi8_zero  | hi8_ones;
    assign ok_cb  = hi19_zero | hi19_ones;
    assign neg_b  = hi26_ones;
    assign neg_d  = hi8_ones;
    assign neg_cb = hi19_ones;
`else
    // Upper immediate bits are discarded when the range check is disabled.
    logic unused_imm_hi;
    assign unused_imm_hi = &{1'b0, Imm[62:26]};
    assign ok_b   = 1'b1;
    assign ok_d   = 1'b1;
    assign ok_cb  = 1'b1;
    assign neg_b  = Imm[63];
    assign neg_d  = Imm[63];
    assign neg_cb = Imm[63];
`endif

    logic        legal;
    logic [31:0] word;
    logic        accept;
    logic        xfer;

    // Build the instruction word; the opcode encodes the extension sign so decode restores Imm.
    always_comb begin
        legal = 1'b0;
        word  = '0;
        case (Fmt)
            FMT_B: begin
                legal = ok_b;
                word  = {(neg_b ? 6'b100101 : 6'b000101), Imm[25:0]};
            end
            FMT_D: begin
                legal = ok_d;
                word  = {(neg_d ? 11'b11111000010 : 11'b11111000000), 1'b0, Imm[7:0], 2'b00, Rn, Rt};
            end
            FMT_CB: begin
                legal = ok_cb;
                word  = {(neg_cb ? 8'b10110101 : 8'b01010100), Imm[18:0], Rt};
            end
            default: begin
                legal = 1'b0;
                word  = '0;
            end
        endcase
    end

    assign In_Ready = !out_valid_q || Out_Ready;
    assign accept   = In_Valid && In_Ready;
    assign xfer     = out_valid_q && Out_Ready;

    // Next-state for the output slot, address counter and error accounting; Clear has the last word.
    always_comb begin
        out_valid_d = out_valid_q;
        inst_d      = inst_q;
        addr_d      = addr_q;
        err_flag_d  = err_flag_q;
        err_cnt_d   = err_cnt_q;
        if (xfer) begin
            out_valid_d = 1'b0;
            addr_d      = addr_q + ADDR_W'(4);
        end
        if (accept) begin
            if (legal) begin
                out_valid_d = 1'b1;
                inst_d      = word;
            end else begin
                err_flag_d = 1'b1;
                if (!(&err_cnt_q)) begin
                    err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                end
            end
        end
        if (Clear) begin
            addr_d     = BASE_ADDR;
            err_flag_d = 1'b0;
            err_cnt_d  = '0;
        end
    end

    // State register; reset drops any held word.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            inst_q      <= '0;
            addr_q      <= BASE_ADDR;
            err_flag_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            inst_q      <= inst_d;
            addr_q      <= addr_d;
            err_flag_q  <= err_flag_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign Out_Valid = out_valid_q;
    assign InstOut   = inst_q;
    assign WrAddr    = addr_q;
    assign ErrFlag   = err_flag_q;
    assign ErrCount  = err_cnt_q;

endmodule
